// File: rtl/gate_pkg.sv
// gate_pkg: shared FSM state encoding and default timing constants for the gate direction detector.
package gate_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E1   = 3'd1,
        E2   = 3'd2,
        E3   = 3'd3,
        X1   = 3'd4,
        X2   = 3'd5,
        X3   = 3'd6
    } gate_state_t;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF  = 1023;
    localparam int DEBOUNCE_CYC_DEF = 15;
endpackage

// File: rtl/sensor_debouncer.sv
// sensor_debouncer: passes a new level only after it has been stable for DEBOUNCE_CYC cycles.
module sensor_debouncer #(
    parameter int DEBOUNCE_CYC = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/gate_direction_detector.sv
// gate_direction_detector: decodes two-beam gate passages into enter/exit/error pulses.
// Optional SENSOR_DEBOUNCE_EN inserts a sensor_debouncer after each synchronizer.
module gate_direction_detector
    import gate_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic enter,
    output logic exit,
    output logic error,
    output logic busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [SYNC_STAGES-1:0] sa, sb;
    logic [1:0] ab, m;
    logic [TW-1:0] cnt;
    gate_state_t state, nxt, s1, s2, s3;
    logic xs, done, err_n, expire;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sa <= '0;
            sb <= '0;
        end else begin
            sa <= {sa[SYNC_STAGES-2:0], sensor_a};
            sb <= {sb[SYNC_STAGES-2:0], sensor_b};
        end
    end

`ifdef SENSOR_DEBOUNCE_EN
    logic qa, qb;
    sensor_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_a (
        .Clock(Clock), .Reset(Reset), .d(sa[SYNC_STAGES-1]), .q(qa)
    );
    sensor_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_b (
        .Clock(Clock), .Reset(Reset), .d(sb[SYNC_STAGES-1]), .q(qb)
    );
    assign ab = {qa, qb};
`else
    assign ab = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};
`endif

    // Outbound states reuse the inbound decode with the sensor pair swapped.
    always_comb begin
        xs = (state == X1) || (state == X2) || (state == X3);
        m  = xs ? {ab[0], ab[1]} : ab;
        s1 = xs ? X1 : E1;
        s2 = xs ? X2 : E2;
        s3 = xs ? X3 : E3;
        nxt   = state;
        done  = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                nxt   = (ab == 2'b10) ? E1 : (ab == 2'b01) ? X1 : IDLE;
                err_n = (ab == 2'b11);
            end
            E1, X1: begin
                nxt   = (m == 2'b11) ? s2 : (m == 2'b10) ? s1 : IDLE;
                err_n = (m == 2'b01);
            end
            E2, X2: begin
                nxt   = (m == 2'b01) ? s3 : (m == 2'b10) ? s1 : (m == 2'b11) ? s2 : IDLE;
                err_n = (m == 2'b00);
            end
            E3, X3: begin
                nxt   = (m == 2'b11) ? s2 : (m == 2'b01) ? s3 : IDLE;
                done  = (m == 2'b00);
                err_n = (m == 2'b10);
            end
            default: nxt = IDLE;
        endcase
        expire = (state != IDLE) && (nxt == state) && (cnt == TW'(TIMEOUT_CYC - 1));
        if (expire) begin
            nxt   = IDLE;
            err_n = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            enter <= 1'b0;
            exit  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= (nxt != IDLE);
            enter <= done && !xs;
            exit  <= done && xs;
            error <= err_n;
            if (nxt == IDLE || nxt != state)
                cnt <= '0;
            else if (cnt != TW'(TIMEOUT_CYC))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_gate_direction_detector.sv
// tb_gate_direction_detector: scoreboard bench; stimulus queues expected pulses, a monitor pops them.
module tb_gate_direction_detector;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int LAT = 18;
    localparam int H   = 20;
    localparam int G   = 16;
`else
    localparam int LAT = 3;
    localparam int H   = 4;
    localparam int G   = 1;
`endif
    localparam int K_ENTER = 1, K_EXIT = 2, K_ERR = 3;

    logic Clock, Reset, sensor_a, sensor_b;
    logic enter, exit, error, busy;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;
    exp_t q[$];

    gate_direction_detector dut (
        .Clock(Clock), .Reset(Reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .enter(enter), .exit(exit), .error(error), .busy(busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input logic a, input logic b, input int hold, input int kind);
        sensor_a = a;
        sensor_b = b;
        if (kind != 0) q.push_back('{kind, cyc + LAT});
        repeat (hold) @(negedge Clock);
    endtask

    always @(negedge Clock) begin
        if (enter || exit || error) begin
            int k;
            exp_t e;
            k = enter ? K_ENTER : exit ? K_EXIT : K_ERR;
            chk("onehot", int'(enter) + int'(exit) + int'(error), 1);
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual kind=%0d at cyc %0d required none", k, cyc);
            end else begin
                e = q.pop_front();
                if (k != e.kind || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                             k, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int seen;
        Reset = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        #2;
        chk("rst_enter", enter, 0);
        chk("rst_exit", exit, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        step(0, 0, H, 0);
        step(1, 0, H, 0);
        step(1, 1, H, 0);
        step(0, 1, H, 0);
        step(0, 0, H, K_ENTER);

        step(0, 1, H, 0);
        step(1, 1, H, 0);
        step(1, 0, H, 0);
        step(0, 0, H, K_EXIT);

        step(1, 0, H, 0);
        step(1, 1, H, 0);
        step(1, 0, H, 0);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (LAT - 1) @(negedge Clock);
        chk("backout_busy_hold", busy, 1);
        @(negedge Clock);
        chk("backout_busy_fall", busy, 0);
        repeat (H) @(negedge Clock);

        sensor_a = 1'b1;
        sensor_b = 1'b1;
        for (int i = 0; i < G; i++) q.push_back('{K_ERR, cyc + LAT + i});
        repeat (G) @(negedge Clock);
        step(0, 0, LAT + G + 2, 0);
        chk("idle11_busy", busy, 0);
        step(1, 0, H, 0);
        step(0, 1, H, K_ERR);
        step(0, 0, H, 0);
        chk("e1_err_idle", busy, 0);

        step(1, 0, H, 0);
        step(1, 1, H, 0);
        step(0, 1, H, 0);
        step(0, 0, G, K_ENTER);
        step(1, 0, H, 0);
        chk("b2b_busy", busy, 1);
        step(1, 1, H, 0);
        step(0, 1, H, 0);
        step(0, 0, H, K_ENTER);

        t0 = cyc;
        sensor_a = 1'b1;
        sensor_b = 1'b0;
        q.push_back('{K_ERR, t0 + LAT + 1023});
        while (cyc < t0 + LAT + 1023) @(negedge Clock);
        chk("timeout_idle", busy, 0);
        while (cyc < t0 + 1100) @(negedge Clock);
        step(0, 0, H, 0);

        step(1, 0, H, 0);
        step(1, 1, H, 0);
        chk("e2_busy", busy, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_enter", enter, 0);
        chk("async_exit", exit, 0);
        chk("async_error", error, 0);
        sensor_a = 1'b0;
        sensor_b = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        step(0, 1, H, 0);
        step(0, 0, H, 0);
        chk("post_rst_busy", busy, 0);

`ifdef SENSOR_DEBOUNCE_EN
        seen = 0;
        sensor_a = 1'b1;
        repeat (5) begin
            @(negedge Clock);
            seen |= busy;
        end
        sensor_a = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            seen |= busy;
        end
        chk("glitch_busy", seen, 0);
`else
        seen = 0;
`endif

        repeat (LAT + 5) @(negedge Clock);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
